// File: rtl/regbank_hot_if.sv
// regbank_hot_if: write, dual-read, write-decode and dirty-mask signals of
// the register bank. The slave modport is the bank side; master is the
// pipeline side.
interface regbank_hot_if #(
  parameter int N  = 32,
  parameter int W  = 32,
  localparam int AW = $clog2(N)
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic [W-1:0]  rd_data_a;
  logic          rd_valid_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_b;
  logic          rd_valid_b;
  logic [N-1:0]  wr_hot;
  logic [N-1:0]  dirty;
  logic          dirty_clr;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, dirty_clr,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, wr_hot, dirty
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, dirty_clr,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, wr_hot, dirty
  );
endinterface

// File: rtl/regbank_hot.sv
// regbank_hot: N x W register bank with one-hot decoded write port, two
// registered read ports (1-cycle latency) and a per-register dirty mask.
// Optional macro REGBANK_BYPASS_EN: a same-cycle read of an address that is
// being written returns the new write data instead of the old contents.

// One register plus its dirty bit.
module regbank_hot_cell #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_we,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_dirty
);
  logic [W-1:0] r_q;
  logic         r_dirty;

  // Data register: loads on its one-hot enable.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  // Dirty bit: a write beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_dirty <= 1'b0;
    else if (i_we)   r_dirty <= 1'b1;
    else if (i_clr)  r_dirty <= 1'b0;
  end

  assign o_q     = r_q;
  assign o_dirty = r_dirty;
endmodule

module regbank_hot #(
  parameter int N        = 32,
  parameter int W        = 32,
  parameter int ZERO_REG = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  regbank_hot_if.slave io_bus
);
  localparam int AW = $clog2(N);

  logic                  w_inrange;
  logic                  w_zero_hit;
  logic                  w_accept;
  logic [N-1:0]          w_hot;
  logic [N-1:0][W-1:0]   w_q;
  logic [N-1:0]          w_dirty;
  logic [W-1:0]          w_rd_a;
  logic [W-1:0]          w_rd_b;

  logic [W-1:0]          r_rd_data_a;
  logic [W-1:0]          r_rd_data_b;
  logic                  r_rd_valid_a;
  logic                  r_rd_valid_b;
  logic [N-1:0]          r_wr_hot;

  // N need not be a power of two, so the address space can exceed N.
  assign w_inrange  = ({1'b0, io_bus.wr_addr} < (AW+1)'(N));
  assign w_zero_hit = (ZERO_REG != 0) && (io_bus.wr_addr == '0);
  assign w_accept   = io_bus.wr_en && w_inrange && !w_zero_hit;

  // One-hot decode and per-register cells; rejected writes give all-zero.
  for (genvar g = 0; g < N; g++) begin : g_reg
    assign w_hot[g] = w_accept && (io_bus.wr_addr == AW'(g));

    regbank_hot_cell #(.W(W)) u_cell (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_hot[g]),
      .i_clr   (io_bus.dirty_clr),
      .i_d     (io_bus.wr_data),
      .o_q     (w_q[g]),
      .o_dirty (w_dirty[g])
    );
  end

  // Port A read mux: unmatched (out-of-range) addresses yield 0. Register 0
  // reads 0 with ZERO_REG because its cell is never enabled.
  always_comb begin
    w_rd_a = '0;
    for (int i = 0; i < N; i++)
      if (io_bus.rd_addr_a == AW'(i)) w_rd_a = w_q[i];
`ifdef REGBANK_BYPASS_EN
    if (w_accept && (io_bus.wr_addr == io_bus.rd_addr_a)) w_rd_a = io_bus.wr_data;
`endif
  end

  // Port B read mux, same rules as port A.
  always_comb begin
    w_rd_b = '0;
    for (int i = 0; i < N; i++)
      if (io_bus.rd_addr_b == AW'(i)) w_rd_b = w_q[i];
`ifdef REGBANK_BYPASS_EN
    if (w_accept && (io_bus.wr_addr == io_bus.rd_addr_b)) w_rd_b = io_bus.wr_data;
`endif
  end

  // Read output registers: valid pulses per request, data holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
    end else begin
      r_rd_valid_a <= io_bus.rd_en_a;
      r_rd_valid_b <= io_bus.rd_en_b;
      if (io_bus.rd_en_a) r_rd_data_a <= w_rd_a;
      if (io_bus.rd_en_b) r_rd_data_b <= w_rd_b;
    end
  end

  // Registered copy of the write decode, a one-cycle pulse per write.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wr_hot <= '0;
    else       r_wr_hot <= w_hot;
  end

  assign io_bus.rd_data_a  = r_rd_data_a;
  assign io_bus.rd_data_b  = r_rd_data_b;
  assign io_bus.rd_valid_a = r_rd_valid_a;
  assign io_bus.rd_valid_b = r_rd_valid_b;
  assign io_bus.wr_hot     = r_wr_hot;
  assign io_bus.dirty      = w_dirty;
endmodule

// File: tb/tb_regbank_hot.sv
// tb_regbank_hot: directed table-driven bench for regbank_hot, with an N=32
// instance for the main vectors and an N=20 instance for out-of-range cases.
module tb_regbank_hot;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regbank_hot_if #(.N(32), .W(32)) b32 ();
  regbank_hot_if #(.N(20), .W(32)) b20 ();

  regbank_hot #(.N(32), .W(32), .ZERO_REG(1)) u32 (.i_clk(clk), .i_rst(rst), .io_bus(b32));
  regbank_hot #(.N(20), .W(32), .ZERO_REG(1)) u20 (.i_clk(clk), .i_rst(rst), .io_bus(b20));

  typedef struct {
    logic        we;   logic [4:0] wa; logic [31:0] wd; logic clr;
    logic        ae;   logic [4:0] aa; logic be;        logic [4:0] ba;
    logic        va;   logic [31:0] da; logic vb;       logic [31:0] db;
    logic [31:0] hot;  logic [31:0] dirty;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic clr,
                              logic ae, logic [4:0] aa, logic be, logic [4:0] ba,
                              logic va, logic [31:0] da, logic vb, logic [31:0] db,
                              logic [31:0] hot, logic [31:0] dirty);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.clr = clr;
    v.ae = ae; v.aa = aa; v.be = be; v.ba = ba;
    v.va = va; v.da = da; v.vb = vb; v.db = db;
    v.hot = hot; v.dirty = dirty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[14];

  initial begin
    b32.wr_en = 0; b32.wr_addr = 0; b32.wr_data = 0; b32.dirty_clr = 0;
    b32.rd_en_a = 0; b32.rd_addr_a = 0; b32.rd_en_b = 0; b32.rd_addr_b = 0;
    b20.wr_en = 0; b20.wr_addr = 0; b20.wr_data = 0; b20.dirty_clr = 0;
    b20.rd_en_a = 0; b20.rd_addr_a = 0; b20.rd_en_b = 0; b20.rd_addr_b = 0;

    //              we wa  wd            clr ae aa  be ba  va da            vb db                          hot           dirty
    tbl[0]  = mk(1, 6,  32'hDEADBEEF, 0,  0, 0,  0, 0,  0, 32'h0,        0, 32'h0,                      32'h40,       32'h40);
    tbl[1]  = mk(0, 0,  32'h0,        0,  1, 6,  0, 0,  1, 32'hDEADBEEF, 0, 32'h0,                      32'h0,        32'h40);
    tbl[2]  = mk(1, 0,  32'h1234,     0,  1, 0,  0, 0,  1, 32'h0,        0, 32'h0,                      32'h0,        32'h40);
    tbl[3]  = mk(0, 0,  32'h0,        0,  1, 0,  0, 0,  1, 32'h0,        0, 32'h0,                      32'h0,        32'h40);
    tbl[4]  = mk(1, 2,  32'h11,       0,  0, 0,  0, 0,  0, 32'h0,        0, 32'h0,                      32'h4,        32'h44);
    tbl[5]  = mk(1, 2,  32'hA5A5A5A5, 0,  0, 0,  1, 2,  0, 32'h0,        1, BYP ? 32'hA5A5A5A5 : 32'h11, 32'h4,        32'h44);
    tbl[6]  = mk(0, 0,  32'h0,        0,  1, 2,  1, 6,  1, 32'hA5A5A5A5, 1, 32'hDEADBEEF,               32'h0,        32'h44);
    tbl[7]  = mk(1, 3,  32'h33,       0,  0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hDEADBEEF,               32'h8,        32'h4C);
    tbl[8]  = mk(1, 9,  32'h99,       1,  0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hDEADBEEF,               32'h200,      32'h200);
    tbl[9]  = mk(0, 0,  32'h0,        0,  0, 0,  0, 0,  0, 32'hA5A5A5A5, 0, 32'hDEADBEEF,               32'h0,        32'h200);
    tbl[10] = mk(0, 0,  32'h0,        0,  1, 9,  1, 3,  1, 32'h99,       1, 32'h33,                     32'h0,        32'h200);
    tbl[11] = mk(0, 0,  32'h0,        1,  0, 0,  0, 0,  0, 32'h99,       0, 32'h33,                     32'h0,        32'h0);
    tbl[12] = mk(1, 31, 32'hFFFF0000, 0,  1, 31, 1, 31, 1, BYP ? 32'hFFFF0000 : 32'h0,
                                                                            1, BYP ? 32'hFFFF0000 : 32'h0, 32'h80000000, 32'h80000000);
    tbl[13] = mk(0, 0,  32'h0,        0,  1, 31, 1, 0,  1, 32'hFFFF0000, 1, 32'h0,                      32'h0,        32'h80000000);

    // Reset state of both instances.
    rst = 1'b1;
    tick(); tick();
    chk("rst32_da", b32.rd_data_a, 0);  chk("rst32_va", {31'b0, b32.rd_valid_a}, 0);
    chk("rst32_db", b32.rd_data_b, 0);  chk("rst32_vb", {31'b0, b32.rd_valid_b}, 0);
    chk("rst32_hot", b32.wr_hot, 0);    chk("rst32_dirty", b32.dirty, 0);
    chk("rst20_va", {31'b0, b20.rd_valid_a}, 0);
    chk("rst20_hot", {12'b0, b20.wr_hot}, 0); chk("rst20_dirty", {12'b0, b20.dirty}, 0);
    rst = 1'b0;

    // Sweep all addresses on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      b32.rd_en_a = 1; b32.rd_addr_a = 5'(i);
      b32.rd_en_b = 1; b32.rd_addr_b = 5'(31 - i);
      tick();
      chk("sweep_va", {31'b0, b32.rd_valid_a}, 1); chk("sweep_da", b32.rd_data_a, 0);
      chk("sweep_vb", {31'b0, b32.rd_valid_b}, 1); chk("sweep_db", b32.rd_data_b, 0);
      chk("sweep_hot", b32.wr_hot, 0);             chk("sweep_dirty", b32.dirty, 0);
    end
    b32.rd_en_a = 0; b32.rd_en_b = 0;
    tick();
    chk("idle_va", {31'b0, b32.rd_valid_a}, 0);
    chk("idle_vb", {31'b0, b32.rd_valid_b}, 0);

    // Table vectors on the N=32 instance; expectations are after each edge.
    for (int k = 0; k < 14; k++) begin
      b32.wr_en = tbl[k].we; b32.wr_addr = tbl[k].wa; b32.wr_data = tbl[k].wd;
      b32.dirty_clr = tbl[k].clr;
      b32.rd_en_a = tbl[k].ae; b32.rd_addr_a = tbl[k].aa;
      b32.rd_en_b = tbl[k].be; b32.rd_addr_b = tbl[k].ba;
      tick();
      chk($sformatf("v%0d_va", k), {31'b0, b32.rd_valid_a}, {31'b0, tbl[k].va});
      chk($sformatf("v%0d_da", k), b32.rd_data_a, tbl[k].da);
      chk($sformatf("v%0d_vb", k), {31'b0, b32.rd_valid_b}, {31'b0, tbl[k].vb});
      chk($sformatf("v%0d_db", k), b32.rd_data_b, tbl[k].db);
      chk($sformatf("v%0d_hot", k), b32.wr_hot, tbl[k].hot);
      chk($sformatf("v%0d_dirty", k), b32.dirty, tbl[k].dirty);
    end
    b32.wr_en = 0; b32.dirty_clr = 0; b32.rd_en_a = 0; b32.rd_en_b = 0;

    // N=20: legal write, then out-of-range write/read.
    b20.wr_en = 1; b20.wr_addr = 5; b20.wr_data = 32'h55;
    tick();
    chk("n20_hot5", {12'b0, b20.wr_hot}, 32'h20);
    chk("n20_dirty5", {12'b0, b20.dirty}, 32'h20);
    b20.wr_addr = 25; b20.wr_data = 32'hBAD;
    b20.rd_en_a = 1; b20.rd_addr_a = 25; b20.rd_en_b = 1; b20.rd_addr_b = 5;
    tick();
    chk("n20_oor_hot", {12'b0, b20.wr_hot}, 0);
    chk("n20_oor_dirty", {12'b0, b20.dirty}, 32'h20);
    chk("n20_oor_va", {31'b0, b20.rd_valid_a}, 1);
    chk("n20_oor_da", b20.rd_data_a, 0);
    chk("n20_r5_db", b20.rd_data_b, 32'h55);
    b20.wr_en = 0;
    tick();
    chk("n20_oor_da2", b20.rd_data_a, 0);
    chk("n20_oor_va2", {31'b0, b20.rd_valid_a}, 1);
    chk("n20_r5_db2", b20.rd_data_b, 32'h55);

    // Reset while both ports of both instances are reading.
    b32.rd_en_a = 1; b32.rd_addr_a = 31; b32.rd_en_b = 1; b32.rd_addr_b = 6;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst32_va", {31'b0, b32.rd_valid_a}, 0);
    chk("mrst32_vb", {31'b0, b32.rd_valid_b}, 0);
    chk("mrst32_dirty", b32.dirty, 0);
    chk("mrst20_va", {31'b0, b20.rd_valid_a}, 0);
    chk("mrst20_vb", {31'b0, b20.rd_valid_b}, 0);
    chk("mrst20_dirty", {12'b0, b20.dirty}, 0);
    b20.rd_addr_a = 5;
    tick();
    chk("post_rst32_da", b32.rd_data_a, 0);
    chk("post_rst32_va", {31'b0, b32.rd_valid_a}, 1);
    chk("post_rst20_da", b20.rd_data_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
